serial_parallel_conv: RTL and testbench

Parametrised serial-to-parallel converter and the successor to the fixed 4-bit SIPO shift register. It adds configurable word width and bit order, a per-bit enable, and word framing via a bit counter and a resync input. The assembled word is presented on a registered output with a valid/ready handshake and a sticky overrun flag. It sits between a serial bit source (e.g. a UART/SPI-style receiver front end) and a parallel consumer.

---
 rtl/serial_parallel_conv_pkg.sv | 15 +
 rtl/serial_parallel_conv_shift_core.sv | 57 +++++
 rtl/serial_parallel_conv.sv | 67 ++++++
 tb/tb_serial_parallel_conv.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parallel_conv_pkg.sv
// Shared definitions for the serial-to-parallel converter: bit-order encodings
// and the bit-counter width helper.
package serial_parallel_conv_pkg;

    localparam bit MSB_FIRST_E = 1'b1;
    localparam bit LSB_FIRST_E = 1'b0;

    // Counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int calc_cw(input int width);
        int cw;
        cw = $clog2(width);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/serial_parallel_conv_shift_core.sv
// Shift register and bit counter that frame the serial stream into words.
// Exposes the word as it will look after the current bit, plus a done strobe.
module sp_shift_core
    import serial_parallel_conv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = MSB_FIRST_E,
    localparam int CW       = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    bit_cnt,
    output logic             done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] fresh;

    // fresh is the current bit dropped into an otherwise cleared register,
    // used when sync restarts framing on a valid bit.
    generate
        if (MSB_FIRST == MSB_FIRST_E) begin : g_msb
            assign word  = {sh[WIDTH-2:0], d_in};
            assign fresh = {{(WIDTH-1){1'b0}}, d_in};
        end else begin : g_lsb
            assign word  = {d_in, sh[WIDTH-1:1]};
            assign fresh = {d_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    assign done = d_valid && !sync && (bit_cnt == LAST);

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (sync) begin
            if (d_valid) begin
                sh      <= fresh;
                bit_cnt <= CW'(1);
            end else begin
                sh      <= '0;
                bit_cnt <= '0;
            end
        end else if (d_valid) begin
            sh      <= word;
            bit_cnt <= done ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_parallel_conv.sv
// Serial-to-parallel converter: frames serial bits into WIDTH-bit words and
// presents them on a registered output with valid/ready and a sticky overrun.
module serial_parallel_conv
    import serial_parallel_conv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = MSB_FIRST_E,
    localparam int CW       = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             sync,
    input  logic             q_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] word;
    logic             done;
    logic             consume;
    logic             ovr_set;

    sp_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk     (clk),
        .CLR     (CLR),
        .d_in    (d_in),
        .d_valid (d_valid),
        .sync    (sync),
        .word    (word),
        .bit_cnt (bit_cnt),
        .done    (done)
    );

    assign consume = q_valid && q_ready;
    // A completion only counts as an overrun if the old word is not being taken now.
    assign ovr_set = done && q_valid && !q_ready;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (done) begin
                q       <= word;
                q_valid <= 1'b1;
            end else if (consume) begin
                q_valid <= 1'b0;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_parallel_conv.sv
// Bench for serial_parallel_conv: three configurations share one stimulus stream,
// each tracked by a bit-list reference model.
module tb_serial_parallel_conv;

    logic clk = 1'b0;
    logic CLR = 1'b1;
    logic din = 1'b0;
    logic dv  = 1'b0;
    logic syn = 1'b0;
    logic qr  = 1'b0;
    logic oc  = 1'b0;

    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic       qv0, qv1, qv2, ov0, ov1, ov2;
    logic [1:0] bc0, bc1;
    logic [2:0] bc2;

    logic [7:0] oq[3];
    logic       oqv[3];
    logic       oov[3];
    logic [7:0] obc[3];

    int   mw[3] = '{4, 4, 8};
    bit   mm[3] = '{1'b1, 1'b0, 1'b1};
    bit   bits[3][8];
    int   nb[3];
    logic [7:0] mq[3];
    logic mqv[3];
    logic mov[3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_parallel_conv #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .CLR(CLR), .d_in(din), .d_valid(dv), .sync(syn), .q_ready(qr),
        .ovr_clr(oc), .q(q0), .q_valid(qv0), .overrun(ov0), .bit_cnt(bc0));
    serial_parallel_conv #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .CLR(CLR), .d_in(din), .d_valid(dv), .sync(syn), .q_ready(qr),
        .ovr_clr(oc), .q(q1), .q_valid(qv1), .overrun(ov1), .bit_cnt(bc1));
    serial_parallel_conv #(.WIDTH(8), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .CLR(CLR), .d_in(din), .d_valid(dv), .sync(syn), .q_ready(qr),
        .ovr_clr(oc), .q(q2), .q_valid(qv2), .overrun(ov2), .bit_cnt(bc2));

    assign oq[0]  = {4'h0, q0};
    assign oq[1]  = {4'h0, q1};
    assign oq[2]  = q2;
    assign oqv[0] = qv0;
    assign oqv[1] = qv1;
    assign oqv[2] = qv2;
    assign oov[0] = ov0;
    assign oov[1] = ov1;
    assign oov[2] = ov2;
    assign obc[0] = {6'h0, bc0};
    assign obc[1] = {6'h0, bc1};
    assign obc[2] = {5'h0, bc2};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            nb[i]  = 0;
            mq[i]  = '0;
            mqv[i] = 1'b0;
            mov[i] = 1'b0;
        end
    endtask

    // Words are collected as a list of received bits and laid out by bit order on completion.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit         complete;
            bit         setov;
            logic [7:0] w;
            complete = 1'b0;
            w = '0;
            if (syn) begin
                nb[i] = 0;
                if (dv) begin
                    bits[i][0] = din;
                    nb[i] = 1;
                end
            end else if (dv) begin
                bits[i][nb[i]] = din;
                nb[i]++;
                if (nb[i] == mw[i]) begin
                    for (int k = 0; k < mw[i]; k++) begin
                        if (mm[i]) w[mw[i]-1-k] = bits[i][k];
                        else       w[k] = bits[i][k];
                    end
                    complete = 1'b1;
                    nb[i] = 0;
                end
            end
            setov = complete && mqv[i] && !qr;
            if (complete) begin
                mq[i]  = w;
                mqv[i] = 1'b1;
            end else if (mqv[i] && qr) begin
                mqv[i] = 1'b0;
            end
            if (setov)   mov[i] = 1'b1;
            else if (oc) mov[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (CLR) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        CLR = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
        din = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [7:0] w);
        for (int k = 0; k < mw[i]; k++)
            send_bit(mm[i] ? w[mw[i]-1-k] : w[k]);
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oq[i] !== 8'h00 || oqv[i] !== 1'b0 || oov[i] !== 1'b0 || obc[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_state inst%0d got q=%h v=%b o=%b c=%0d want all zero",
                         i, oq[i], oqv[i], oov[i], obc[i]);
            end
        end
        din = 1'b1;
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oq[i] !== 8'h00 || oqv[i] !== 1'b0 || obc[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_hold inst%0d got q=%h v=%b c=%0d want all zero",
                         i, oq[i], oqv[i], obc[i]);
            end
        end
        CLR = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        qr = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (q0 !== 4'b1010 || qv0 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_msb got q=%b v=%b o=%b want q=1010 v=1 o=0", q0, qv0, ov0);
        end
        checks++;
        if (q1 !== 4'b0101 || q1 !== mq[1][3:0]) begin
            errors++;
            $display("[TB] FAIL basic_lsb got q=%b want 0101", q1);
        end
        tick();
        checks++;
        if (qv0 !== 1'b0 || q0 !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL basic_consume got q=%b v=%b want q=1010 v=0", q0, qv0);
        end
        qr = 1'b0;
    endtask

    task automatic test_gaps();
        logic tdv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic tdi[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int   tbc[7] = '{1, 2, 2, 2, 2, 3, 0};
        do_reset();
        qr = 1'b1;
        for (int s = 0; s < 7; s++) begin
            din = tdi[s];
            dv  = tdv[s];
            tick();
            checks++;
            if (int'(bc1) != tbc[s]) begin
                errors++;
                $display("[TB] FAIL gap_bitcnt step%0d got %0d want %0d", s, bc1, tbc[s]);
            end
        end
        dv = 1'b0;
        checks++;
        if (q1 !== 4'b0101 || qv1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_word got q=%b v=%b want q=0101 v=1", q1, qv1);
        end
        qr = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        qr = 1'b0;
        send_word(2, 8'hA5);
        checks++;
        if (q2 !== 8'hA5 || qv2 !== 1'b1 || ov2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_first got q=%h v=%b o=%b want q=a5 v=1 o=0", q2, qv2, ov2);
        end
        send_word(2, 8'h3C);
        checks++;
        if (q2 !== 8'h3C || qv2 !== 1'b1 || ov2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_set got q=%h v=%b o=%b want q=3c v=1 o=1", q2, qv2, ov2);
        end
        checks++;
        if (q0 !== mq[0][3:0] || ov0 !== mov[0] || ov1 !== mov[1]) begin
            errors++;
            $display("[TB] FAIL ovr_narrow got q=%h o=%b/%b want q=%h o=%b/%b",
                     q0, ov0, ov1, mq[0][3:0], mov[0], mov[1]);
        end
        oc = 1'b1;
        tick();
        oc = 1'b0;
        checks++;
        if (ov2 !== 1'b0 || q2 !== 8'h3C || qv2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_clear got q=%h v=%b o=%b want q=3c v=1 o=0", q2, qv2, ov2);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] nw;
        do_reset();
        qr = 1'b0;
        send_word(0, 8'h03);
        checks++;
        if (qv0 !== 1'b1 || q0 !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL b2b_first got q=%b v=%b want q=0011 v=1", q0, qv0);
        end
        nw = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            din = nw[3-k];
            dv  = 1'b1;
            qr  = (k == 3);
            tick();
        end
        dv = 1'b0;
        qr = 1'b0;
        checks++;
        if (q0 !== 4'b1100 || qv0 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_same_edge got q=%b v=%b o=%b want q=1100 v=1 o=0", q0, qv0, ov0);
        end
    endtask

    task automatic test_sync();
        do_reset();
        qr = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        syn = 1'b1;
        send_bit(1'b0);
        syn = 1'b0;
        checks++;
        if (bc0 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL sync_bitcnt got %0d want 1", bc0);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (q0 !== 4'b0110 || qv0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_word got q=%b v=%b want q=0110 v=1", q0, qv0);
        end
        qr = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        qr = 1'b0;
        send_word(0, 8'h0A);
        send_word(0, 8'h05);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (ov0 !== 1'b1 || q0 !== 4'h5 || bc0 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL areset_pre got q=%h o=%b c=%0d want q=5 o=1 c=2", q0, ov0, bc0);
        end
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oq[i] !== 8'h00 || oqv[i] !== 1'b0 || oov[i] !== 1'b0 || obc[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL areset_now inst%0d got q=%h v=%b o=%b c=%0d want all zero",
                         i, oq[i], oqv[i], oov[i], obc[i]);
            end
        end
        @(posedge clk);
        #1;
        CLR = 1'b0;
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        checks++;
        if (q0 !== 4'hF || qv0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_after got q=%h v=%b want q=f v=1", q0, qv0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            dv  = ($urandom_range(0, 99) < 70);
            din = $urandom_range(0, 1);
            syn = ($urandom_range(0, 99) < 5);
            qr  = ($urandom_range(0, 99) < 50);
            oc  = ($urandom_range(0, 99) < 10);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (oq[i] !== mq[i] || oqv[i] !== mqv[i] || oov[i] !== mov[i] ||
                    obc[i] !== 8'(nb[i])) begin
                    errors++;
                    $display("[TB] FAIL random cyc%0d inst%0d got q=%h v=%b o=%b c=%0d want q=%h v=%b o=%b c=%0d",
                             c, i, oq[i], oqv[i], oov[i], obc[i], mq[i], mqv[i], mov[i], nb[i]);
                end
            end
        end
        dv  = 1'b0;
        syn = 1'b0;
        qr  = 1'b0;
        oc  = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_sync();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got no finish want finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
